// File: rtl/ring_anim_sequencer_if.sv
// Signal bundle between the sync generator / TT pins and the ring animation sequencer.
// The sequencer sits on the slave side; the board-level environment drives the master side.
interface ring_anim_sequencer_if;
   logic       frame_tick;
   logic       btn_mode;
   logic       btn_next;
   logic       sw_speed;
   logic       sw_dir;
   logic [7:0] phase;
   logic       dir;
   logic [2:0] step;
   logic [1:0] palette;
   logic       auto_mode;
   logic [2:0] state;

   modport master (
      output frame_tick, btn_mode, btn_next, sw_speed, sw_dir,
      input  phase, dir, step, palette, auto_mode, state
   );

   modport slave (
      input  frame_tick, btn_mode, btn_next, sw_speed, sw_dir,
      output phase, dir, step, palette, auto_mode, state
   );
endinterface

// File: rtl/ring_anim_sequencer.sv
// Per-frame phase/direction/speed controller for the concentric-rings renderer.
// MANUAL follows the switches; AUTO runs ramp-up/run/ramp-down/hold/reverse and then repeats.
module ring_anim_sequencer #(
   parameter int RUN_FRAMES  = 240,
   parameter int HOLD_FRAMES = 60,
   parameter int MAX_STEP    = 4,
   parameter int DEB_BITS    = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   ring_anim_sequencer_if.slave bus
);

   localparam logic [2:0] FULL_STEP = 3'(MAX_STEP);
   localparam logic [9:0] RUN_LAST  = 10'(RUN_FRAMES - 1);
   localparam logic [9:0] HOLD_LAST = 10'(HOLD_FRAMES - 1);

   typedef enum logic [2:0] {
      S_MANUAL    = 3'd0,
      S_RAMP_UP   = 3'd1,
      S_RUN       = 3'd2,
      S_RAMP_DOWN = 3'd3,
      S_HOLD      = 3'd4
   } state_t;

   logic [3:0] sync1, sync2;
   logic [1:0] btn_sync;                // [1] = mode, [0] = next
   logic       sw_speed_s, sw_dir_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         // NOTE: non-blocking, so sync2 samples sync1's previous value and the chain really is two flops deep.
         sync1 <= {bus.btn_mode, bus.btn_next, bus.sw_speed, bus.sw_dir};
         sync2 <= sync1;
      end
   end

   assign btn_sync   = sync2[3:2];
   assign sw_speed_s = sync2[1];
   assign sw_dir_s   = sync2[0];

   logic [DEB_BITS-1:0] deb_cnt [2];
   logic [1:0]          accepted, accepted_q, pending, press, req;
   logic                mode_req, next_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the debounce counter array is reset too; a stale count could accept a level early after reset.
         for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
         accepted   <= '0;
         accepted_q <= '0;
         pending    <= '0;
      end else begin
         accepted_q <= accepted;
         for (int i = 0; i < 2; i++) begin
            if (btn_sync[i] == accepted[i]) begin
               deb_cnt[i] <= '0;
            end else if (&deb_cnt[i]) begin
               accepted[i] <= btn_sync[i];
               deb_cnt[i]  <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DEB_BITS'(1);
            end
         end
         pending <= bus.frame_tick ? 2'b00 : (pending | press);
      end
   end

   // accepted_q is also cleared by reset, so releasing reset cannot fake a rising edge.
   assign press    = accepted & ~accepted_q;
   assign req      = pending | press;
   assign mode_req = req[1];
   assign next_req = req[0] & ~req[1];

   state_t     state_q, state_d;
   logic [2:0] step_q, step_d;
   logic       dir_q, dir_d;
   logic [1:0] palette_q, palette_d;
   logic       auto_q, auto_d;
   logic [7:0] phase_q, phase_d;
   logic [9:0] cnt_q, cnt_d;
   logic [2:0] step_inc, step_dec, manual_step;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_MANUAL;
         step_q    <= '0;
         dir_q     <= 1'b0;
         palette_q <= '0;
         auto_q    <= 1'b0;
         phase_q   <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         dir_q     <= dir_d;
         palette_q <= palette_d;
         auto_q    <= auto_d;
         phase_q   <= phase_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      // NOTE: every output holds its current value first, so no path through this block can infer a latch.
      state_d     = state_q;
      step_d      = step_q;
      dir_d       = dir_q;
      palette_d   = palette_q;
      auto_d      = auto_q;
      phase_d     = phase_q;
      cnt_d       = cnt_q;
      step_inc    = step_q + 3'd1;
      step_dec    = step_q - 3'd1;
      manual_step = sw_speed_s ? 3'd2 : 3'd1;

      if (bus.frame_tick) begin
         // Phase advances with the parameters the frame just rendered with.
         phase_d = dir_q ? phase_q - 8'(step_q) : phase_q + 8'(step_q);

         if (mode_req) begin
            if (state_q == S_MANUAL) begin
               state_d = S_RAMP_UP;
               step_d  = 3'd0;
               cnt_d   = '0;
               auto_d  = 1'b1;
            end else begin
               state_d = S_MANUAL;
               step_d  = manual_step;
               dir_d   = sw_dir_s;
               auto_d  = 1'b0;
            end
         end else begin
            case (state_q)
               S_MANUAL: begin
                  step_d = manual_step;
                  dir_d  = sw_dir_s;
               end
               S_RAMP_UP: begin
                  if (next_req || step_inc == FULL_STEP) begin
                     state_d = S_RUN;
                     step_d  = FULL_STEP;
                     cnt_d   = '0;
                  end else begin
                     step_d = step_inc;
                  end
               end
               S_RUN: begin
                  if (next_req || cnt_q == RUN_LAST) state_d = S_RAMP_DOWN;
                  else                               cnt_d   = cnt_q + 10'd1;
               end
               S_RAMP_DOWN: begin
                  if (next_req || step_dec == 3'd0) begin
                     state_d = S_HOLD;
                     step_d  = 3'd0;
                     cnt_d   = '0;
                  end else begin
                     step_d = step_dec;
                  end
               end
               S_HOLD: begin
                  if (next_req || cnt_q == HOLD_LAST) begin
                     state_d   = S_RAMP_UP;
                     dir_d     = ~dir_q;
                     palette_d = palette_q + 2'd1;
                     cnt_d     = '0;
                  end else begin
                     cnt_d = cnt_q + 10'd1;
                  end
               end
               default: state_d = S_MANUAL;
            endcase
         end
      end
   end

   assign bus.phase     = phase_q;
   assign bus.dir       = dir_q;
   assign bus.step      = step_q;
   assign bus.palette   = palette_q;
   assign bus.auto_mode = auto_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_ring_anim_sequencer.sv
// Directed bench for ring_anim_sequencer: table of per-frame vectors plus hand-written reset/debounce sequences.
// Built with RUN_FRAMES=3, HOLD_FRAMES=2, MAX_STEP=4, DEB_BITS=4 so a full AUTO cycle fits in a few frames.
module tb_ring_anim_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ring_anim_sequencer_if bus ();

   ring_anim_sequencer #(
      .RUN_FRAMES (3),
      .HOLD_FRAMES(2),
      .MAX_STEP   (4),
      .DEB_BITS   (4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef enum {P_NONE, P_MODE, P_NEXT, P_BOTH, P_BOUNCE} press_t;

   typedef struct {
      logic        sw_speed;
      logic        sw_dir;
      press_t      press;
      logic [17:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [17:0] dut_out;
   assign dut_out = {bus.phase, bus.dir, bus.step, bus.palette, bus.auto_mode, bus.state};

   // {phase, dir, step, palette, auto_mode, state}
   function automatic logic [17:0] pk(input logic [7:0] ph, input logic d, input logic [2:0] st,
                                      input logic [1:0] pal, input logic a, input logic [2:0] s);
      return {ph, d, st, pal, a, s};
   endfunction

   task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got phase=%0d dir=%0d step=%0d pal=%0d auto=%0d state=%0d, expected phase=%0d dir=%0d step=%0d pal=%0d auto=%0d state=%0d",
                  name, got[17:10], got[9], got[8:6], got[5:4], got[3], got[2:0],
                  exp[17:10], exp[9], exp[8:6], exp[5:4], exp[3], exp[2:0]);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick();
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
   endtask

   task automatic press_btn(input logic m, input logic nx);
      bus.btn_mode = m;
      bus.btn_next = nx;
      cycles(24);
      bus.btn_mode = 1'b0;
      bus.btn_next = 1'b0;
      cycles(24);
   endtask

   task automatic bounce_mode();
      for (int i = 0; i < 10; i++) begin
         bus.btn_mode = i[0];
         cycles(1);
      end
      bus.btn_mode = 1'b1;
      cycles(20);
      bus.btn_mode = 1'b0;
      cycles(24);
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.frame_tick = 1'b0;
      bus.btn_mode   = 1'b0;
      bus.btn_next   = 1'b0;
      bus.sw_speed   = 1'b1;
      bus.sw_dir     = 1'b0;

      // sw_speed sw_dir press     phase dir step pal auto state
      vecs.push_back('{1'b0, 1'b1, P_NONE,   pk(8'd0,   1'b1, 3'd1, 2'd0, 1'b0, 3'd0)});
      vecs.push_back('{1'b0, 1'b1, P_NONE,   pk(8'd255, 1'b1, 3'd1, 2'd0, 1'b0, 3'd0)});
      vecs.push_back('{1'b0, 1'b1, P_NONE,   pk(8'd254, 1'b1, 3'd1, 2'd0, 1'b0, 3'd0)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd253, 1'b0, 3'd2, 2'd0, 1'b0, 3'd0)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd255, 1'b0, 3'd2, 2'd0, 1'b0, 3'd0)});
      vecs.push_back('{1'b1, 1'b0, P_BOUNCE, pk(8'd1,   1'b0, 3'd0, 2'd0, 1'b1, 3'd1)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd1,   1'b0, 3'd1, 2'd0, 1'b1, 3'd1)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd2,   1'b0, 3'd2, 2'd0, 1'b1, 3'd1)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd4,   1'b0, 3'd3, 2'd0, 1'b1, 3'd1)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd7,   1'b0, 3'd4, 2'd0, 1'b1, 3'd2)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd11,  1'b0, 3'd4, 2'd0, 1'b1, 3'd2)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd15,  1'b0, 3'd4, 2'd0, 1'b1, 3'd2)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd19,  1'b0, 3'd4, 2'd0, 1'b1, 3'd3)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd23,  1'b0, 3'd3, 2'd0, 1'b1, 3'd3)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd26,  1'b0, 3'd2, 2'd0, 1'b1, 3'd3)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd28,  1'b0, 3'd1, 2'd0, 1'b1, 3'd3)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd29,  1'b0, 3'd0, 2'd0, 1'b1, 3'd4)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd29,  1'b0, 3'd0, 2'd0, 1'b1, 3'd4)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd29,  1'b1, 3'd0, 2'd1, 1'b1, 3'd1)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd29,  1'b1, 3'd1, 2'd1, 1'b1, 3'd1)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd28,  1'b1, 3'd2, 2'd1, 1'b1, 3'd1)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd26,  1'b1, 3'd3, 2'd1, 1'b1, 3'd1)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd23,  1'b1, 3'd4, 2'd1, 1'b1, 3'd2)});
      vecs.push_back('{1'b1, 1'b0, P_NEXT,   pk(8'd19,  1'b1, 3'd4, 2'd1, 1'b1, 3'd3)});
      vecs.push_back('{1'b1, 1'b0, P_NONE,   pk(8'd15,  1'b1, 3'd3, 2'd1, 1'b1, 3'd3)});
      vecs.push_back('{1'b1, 1'b0, P_NEXT,   pk(8'd12,  1'b1, 3'd0, 2'd1, 1'b1, 3'd4)});
      vecs.push_back('{1'b1, 1'b1, P_BOTH,   pk(8'd12,  1'b1, 3'd2, 2'd1, 1'b0, 3'd0)});
      vecs.push_back('{1'b1, 1'b1, P_NONE,   pk(8'd10,  1'b1, 3'd2, 2'd1, 1'b0, 3'd0)});
      vecs.push_back('{1'b1, 1'b1, P_NEXT,   pk(8'd8,   1'b1, 3'd2, 2'd1, 1'b0, 3'd0)});
      vecs.push_back('{1'b1, 1'b1, P_MODE,   pk(8'd6,   1'b1, 3'd0, 2'd1, 1'b1, 3'd1)});
      vecs.push_back('{1'b1, 1'b1, P_NONE,   pk(8'd6,   1'b1, 3'd1, 2'd1, 1'b1, 3'd1)});
      vecs.push_back('{1'b1, 1'b1, P_NONE,   pk(8'd5,   1'b1, 3'd2, 2'd1, 1'b1, 3'd1)});
      vecs.push_back('{1'b1, 1'b1, P_NONE,   pk(8'd3,   1'b1, 3'd3, 2'd1, 1'b1, 3'd1)});
      vecs.push_back('{1'b1, 1'b1, P_NONE,   pk(8'd0,   1'b1, 3'd4, 2'd1, 1'b1, 3'd2)});
      vecs.push_back('{1'b1, 1'b1, P_NONE,   pk(8'd252, 1'b1, 3'd4, 2'd1, 1'b1, 3'd2)});
      vecs.push_back('{1'b0, 1'b0, P_MODE,   pk(8'd248, 1'b0, 3'd1, 2'd1, 1'b0, 3'd0)});
      vecs.push_back('{1'b0, 1'b0, P_MODE,   pk(8'd249, 1'b0, 3'd0, 2'd1, 1'b1, 3'd1)});
      vecs.push_back('{1'b0, 1'b0, P_NONE,   pk(8'd249, 1'b0, 3'd1, 2'd1, 1'b1, 3'd1)});
      vecs.push_back('{1'b0, 1'b0, P_NONE,   pk(8'd250, 1'b0, 3'd2, 2'd1, 1'b1, 3'd1)});
      vecs.push_back('{1'b0, 1'b0, P_NONE,   pk(8'd252, 1'b0, 3'd3, 2'd1, 1'b1, 3'd1)});
      vecs.push_back('{1'b0, 1'b0, P_NONE,   pk(8'd255, 1'b0, 3'd4, 2'd1, 1'b1, 3'd2)});
      vecs.push_back('{1'b0, 1'b0, P_NONE,   pk(8'd3,   1'b0, 3'd4, 2'd1, 1'b1, 3'd2)});
      vecs.push_back('{1'b0, 1'b0, P_NONE,   pk(8'd7,   1'b0, 3'd4, 2'd1, 1'b1, 3'd2)});
      vecs.push_back('{1'b0, 1'b0, P_NONE,   pk(8'd11,  1'b0, 3'd4, 2'd1, 1'b1, 3'd3)});
      vecs.push_back('{1'b0, 1'b0, P_NONE,   pk(8'd15,  1'b0, 3'd3, 2'd1, 1'b1, 3'd3)});

      // Reset state, then MANUAL at step 2 outward: first tick still uses the reset step of 0.
      cycles(3);
      check("reset", dut_out, pk(8'd0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0));
      rst_n = 1'b1;
      cycles(4);
      tick();
      check("manual_t1", dut_out, pk(8'd0, 1'b0, 3'd2, 2'd0, 1'b0, 3'd0));
      cycles(5);
      check("manual_t1_hold", dut_out, pk(8'd0, 1'b0, 3'd2, 2'd0, 1'b0, 3'd0));
      tick();
      check("manual_t2", dut_out, pk(8'd2, 1'b0, 3'd2, 2'd0, 1'b0, 3'd0));
      tick();
      check("manual_t3", dut_out, pk(8'd4, 1'b0, 3'd2, 2'd0, 1'b0, 3'd0));

      // Re-reset so the inward table rows start from phase 0 and exercise the wrap.
      rst_n = 1'b0;
      #1;
      check("rereset", dut_out, pk(8'd0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0));
      bus.sw_speed = 1'b0;
      bus.sw_dir   = 1'b1;
      cycles(2);
      rst_n = 1'b1;
      cycles(4);

      foreach (vecs[r]) begin
         bus.sw_speed = vecs[r].sw_speed;
         bus.sw_dir   = vecs[r].sw_dir;
         cycles(3);
         case (vecs[r].press)
            P_MODE:   press_btn(1'b1, 1'b0);
            P_NEXT:   press_btn(1'b0, 1'b1);
            P_BOTH:   press_btn(1'b1, 1'b1);
            P_BOUNCE: bounce_mode();
            default:  ;
         endcase
         tick();
         check($sformatf("row%0d", r), dut_out, vecs[r].exp);
         cycles(3);
         check($sformatf("row%0d_hold", r), dut_out, vecs[r].exp);
      end

      // Mid-RAMP_DOWN with a mode press pending: async reset must clear outputs and the pending press.
      press_btn(1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      check("async_reset", dut_out, pk(8'd0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0));
      cycles(3);
      rst_n = 1'b1;
      cycles(30);
      tick();
      check("post_reset_t1", dut_out, pk(8'd0, 1'b0, 3'd1, 2'd0, 1'b0, 3'd0));
      tick();
      check("post_reset_t2", dut_out, pk(8'd1, 1'b0, 3'd1, 2'd0, 1'b0, 3'd0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
